// File: rtl/acc_stream_host.sv
// Streams NWORDS samples to an accelerator, then collects its results into a host-side FWFT FIFO.
// Define ACC_STREAM_TIMEOUT_EN to build in the 12-bit stall watchdog; otherwise timeout is tied low.
module acc_stream_host #(
  parameter int WIDTH     = 32,
  parameter int NWORDS    = 1024,
  parameter int RES_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [10:0]          batch_size,
  input  logic [WIDTH-1:0]     src_data,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic [WIDTH-1:0]     acc_ax,
  output logic                 acc_input_valid,
  input  logic                 acc_input_ready,
  output logic [10:0]          acc_batch_size,
  input  logic [2*WIDTH-1:0]   acc_res,
  input  logic                 acc_output_valid,
  output logic                 acc_output_ready,
  input  logic                 rd_en,
  output logic [2*WIDTH-1:0]   rd_data,
  output logic                 rd_empty,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 timeout,
  output logic [10:0]          sent_count,
  output logic [5:0]           res_count
);

  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW = $clog2(RES_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

  state_t             state;
  logic [5:0]         expected;
  logic [5:0]         exp_next;
  logic               legal;
  logic [2*WIDTH-1:0] mem [RES_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      fill;
  logic               full, push, pop, xfer;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Only power-of-two batch sizes are legal, so the result count is a constant per case.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    legal    = 1'b1;
    exp_next = '0;
    case (batch_size)
      11'd32:   exp_next = 6'(NWORDS / 32 + 1);
      11'd64:   exp_next = 6'(NWORDS / 64 + 1);
      11'd128:  exp_next = 6'(NWORDS / 128 + 1);
      11'd256:  exp_next = 6'(NWORDS / 256 + 1);
      11'd512:  exp_next = 6'(NWORDS / 512 + 1);
      11'd1024: exp_next = 6'(NWORDS / 1024 + 1);
      default:  legal    = 1'b0;
    endcase
  end

  assign src_ready        = (state == SEND) && acc_input_ready;
  assign acc_input_valid  = (state == SEND) && src_valid;
  assign acc_ax           = (state == SEND) ? src_data : '0;
  assign xfer             = src_valid && src_ready;
  assign full             = (fill == CW'(RES_DEPTH));
  assign rd_empty         = (fill == '0);
  assign acc_output_ready = (state == DRAIN) && !full;
  assign push             = acc_output_valid && acc_output_ready;
  assign pop              = rd_en && !rd_empty;
  assign rd_data          = rd_empty ? '0 : mem[rd_ptr];
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);

`ifdef ACC_STREAM_TIMEOUT_EN
  logic [11:0] wd;
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only; a later assignment in the
  // same block (the watchdog abort) deliberately overrides the case-statement next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      acc_batch_size <= '0;
      expected       <= '0;
      sent_count     <= '0;
      res_count      <= '0;
      err            <= 1'b0;
`ifdef ACC_STREAM_TIMEOUT_EN
      wd             <= '0;
      timeout        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              acc_batch_size <= batch_size;
              expected       <= exp_next;
              sent_count     <= '0;
              res_count      <= '0;
              err            <= 1'b0;
              state          <= SEND;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SEND: begin
          if (xfer) begin
            sent_count <= sent_count + 11'd1;
            if (sent_count == 11'(NWORDS - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (push) begin
            res_count <= res_count + 6'd1;
            if (res_count + 6'd1 == expected) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef ACC_STREAM_TIMEOUT_EN
      if (state == SEND || state == DRAIN) begin
        if (xfer || push) begin
          wd <= '0;
        end else if (wd == 12'hFFF) begin
          timeout <= 1'b1;
          state   <= IDLE;
          wd      <= '0;
        end else begin
          wd <= wd + 12'd1;
        end
      end else begin
        wd <= '0;
      end
      if (state == IDLE && start && legal) timeout <= 1'b0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // NOTE: the storage array is not reset; fill/pointers define validity and rd_data is masked when empty.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= acc_res;
  end

endmodule

// File: tb/tb_acc_stream_host.sv
// Directed bench for acc_stream_host: batch-size legality table plus hand-built job sequences.
// Build with ACC_STREAM_TIMEOUT_EN defined to exercise the watchdog expectations.
module tb_acc_stream_host;
  localparam int WIDTH     = 32;
  localparam int NWORDS    = 1024;
  localparam int RES_DEPTH = 4;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic [10:0]          batch_size = '0;
  logic [WIDTH-1:0]     src_data = '0;
  logic                 src_valid = 1'b0;
  logic                 src_ready;
  logic [WIDTH-1:0]     acc_ax;
  logic                 acc_input_valid;
  logic                 acc_input_ready = 1'b0;
  logic [10:0]          acc_batch_size;
  logic [2*WIDTH-1:0]   acc_res = '0;
  logic                 acc_output_valid = 1'b0;
  logic                 acc_output_ready;
  logic                 rd_en = 1'b0;
  logic [2*WIDTH-1:0]   rd_data;
  logic                 rd_empty;
  logic                 busy, done, err, timeout;
  logic [10:0]          sent_count;
  logic [5:0]           res_count;

  int checks = 0;
  int failures = 0;

  acc_stream_host #(.WIDTH(WIDTH), .NWORDS(NWORDS), .RES_DEPTH(RES_DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .batch_size(batch_size),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .acc_ax(acc_ax), .acc_input_valid(acc_input_valid), .acc_input_ready(acc_input_ready),
    .acc_batch_size(acc_batch_size), .acc_res(acc_res), .acc_output_valid(acc_output_valid),
    .acc_output_ready(acc_output_ready), .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .busy(busy), .done(done), .err(err), .timeout(timeout),
    .sent_count(sent_count), .res_count(res_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] res_pat(input int seed, input int k);
    return {32'(seed) ^ 32'hA5A5_0000, 32'(k * 3 + 11)};
  endfunction

  function automatic logic [31:0] word_pat(input int seed, input int k);
    return 32'(seed * 65536 + k * 7 + 1);
  endfunction

  task automatic do_reset();
    start = 1'b0; src_valid = 1'b0; acc_input_ready = 1'b0;
    acc_output_valid = 1'b0; rd_en = 1'b0;
    #2 reset_n = 1'b0;
    #10 reset_n = 1'b1;
    tick();
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic start_job(input logic [10:0] bs);
    batch_size = bs;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Acts as source, accelerator and (optionally) host reader for one job.
  task automatic run_job(input logic [10:0] bs, input int nres, input int seed,
                         input bit rnd, input bit host_rd,
                         output int words, output int bad, output int pushes,
                         output int pops, output int dones, output int early);
    int res_idx = 0;
    int cyc = 0;
    bit x, p, q;
    words = 0; bad = 0; pushes = 0; pops = 0; dones = 0; early = 0;
    start_job(bs);
    while (cyc < 20000) begin
      src_valid        = rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      src_data         = word_pat(seed, words);
      acc_input_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc_output_valid = (res_idx < nres);
      acc_res          = res_pat(seed, res_idx);
      rd_en            = host_rd && !rd_empty;
      #1;
      x = src_valid && src_ready;
      p = acc_output_valid && acc_output_ready;
      q = rd_en;
      if (x && acc_ax !== word_pat(seed, words)) bad++;
      if (acc_output_ready && sent_count != 11'(NWORDS)) early++;
      if (q) begin
        if (rd_data !== res_pat(seed, pops)) bad++;
        pops++;
      end
      tick();
      if (x) words++;
      if (p) begin res_idx++; pushes++; end
      if (done) dones++;
      else if (dones > 0 && !busy) break;
      cyc++;
    end
    rd_en = 1'b0; src_valid = 1'b0; acc_output_valid = 1'b0;
  endtask

  task automatic drive_cycles(input int n, input int seed, inout int res_idx);
    bit p;
    for (int i = 0; i < n; i++) begin
      acc_res = res_pat(seed, res_idx);
      #1;
      p = acc_output_valid && acc_output_ready;
      tick();
      if (p) res_idx++;
    end
  endtask

  typedef struct {
    logic [10:0] bs;
    logic        exp_err;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int words, bad, pushes, pops, dones, early, res_idx, n, dn;

    vecs[0]  = '{11'd32,   1'b0, 1'b1};
    vecs[1]  = '{11'd64,   1'b0, 1'b1};
    vecs[2]  = '{11'd128,  1'b0, 1'b1};
    vecs[3]  = '{11'd256,  1'b0, 1'b1};
    vecs[4]  = '{11'd512,  1'b0, 1'b1};
    vecs[5]  = '{11'd1024, 1'b0, 1'b1};
    vecs[6]  = '{11'd48,   1'b1, 1'b0};
    vecs[7]  = '{11'd0,    1'b1, 1'b0};
    vecs[8]  = '{11'd33,   1'b1, 1'b0};
    vecs[9]  = '{11'd1023, 1'b1, 1'b0};
    vecs[10] = '{11'd2047, 1'b1, 1'b0};
    vecs[11] = '{11'd16,   1'b1, 1'b0};

    // Reset state while reset_n is held low.
    #3;
    check("rst_rd_empty", rd_empty, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_timeout", timeout, 0);
    check("rst_sent_count", sent_count, 0);
    check("rst_res_count", res_count, 0);
    check("rst_acc_batch_size", acc_batch_size, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_ready_valid", {src_ready, acc_output_ready, acc_input_valid}, 0);
    check("rst_acc_ax", acc_ax, 0);
    #10 reset_n = 1'b1;
    tick();

    // Legality table: each start issued from a fresh reset.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      acc_input_ready = 1'b1;
      start_job(vecs[i].bs);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_src_ready", i), src_ready, vecs[i].exp_busy);
      check($sformatf("vec%0d_acc_batch_size", i), acc_batch_size,
            vecs[i].exp_busy ? vecs[i].bs : 11'd0);
    end

    // Batch 1024: two results expected; a third offered result must stay pending.
    do_reset();
    run_job(11'd1024, 3, 1, 1'b0, 1'b0, words, bad, pushes, pops, dones, early);
    check("j1024_words", words, NWORDS);
    check("j1024_bad", bad, 0);
    check("j1024_pushes", pushes, 2);
    check("j1024_dones", dones, 1);
    check("j1024_early_ready", early, 0);
    check("j1024_res_count", res_count, 2);
    check("j1024_sent_count", sent_count, NWORDS);
    check("j1024_busy", busy, 0);
    check("j1024_not_empty", rd_empty, 0);
    check("j1024_head0", rd_data, res_pat(1, 0));
    pop_one();
    check("j1024_head1", rd_data, res_pat(1, 1));
    pop_one();
    check("j1024_empty", rd_empty, 1);
    check("j1024_rd_data_empty", rd_data, 0);
    pop_one();
    check("j1024_pop_empty_ignored", rd_empty, 1);

    // Batch 32 with random backpressure; host drains concurrently.
    run_job(11'd32, 34, 2, 1'b1, 1'b1, words, bad, pushes, pops, dones, early);
    check("j32_words", words, NWORDS);
    check("j32_pushes", pushes, 33);
    check("j32_dones", dones, 1);
    check("j32_early_ready", early, 0);
    check("j32_res_count", res_count, 33);
    check("j32_sent_count", sent_count, NWORDS);
    for (int k = 0; k < 8 && !rd_empty; k++) begin
      if (rd_data !== res_pat(2, pops)) bad++;
      pop_one();
      pops++;
    end
    check("j32_bad", bad, 0);
    check("j32_total_pops", pops, 33);

    // Illegal start sets err; a legal start clears it; start is ignored mid-job.
    do_reset();
    acc_input_ready = 1'b1;
    start_job(11'd48);
    check("ill48_err", err, 1);
    check("ill48_busy", busy, 0);
    check("ill48_src_ready", src_ready, 0);
    start_job(11'd64);
    check("leg64_err", err, 0);
    check("leg64_busy", busy, 1);
    check("leg64_acc_batch_size", acc_batch_size, 64);
    start_job(11'd48);
    check("midjob_start_err", err, 0);
    check("midjob_acc_batch_size", acc_batch_size, 64);
    check("midjob_busy", busy, 1);

    // Host not reading: FIFO fills after 4 results, one pop admits exactly one more.
    do_reset();
    res_idx = 0;
    src_valid = 1'b1; acc_input_ready = 1'b1; acc_output_valid = 1'b1;
    start_job(11'd32);
    drive_cycles(NWORDS + 20, 3, res_idx);
    check("full_sent_count", sent_count, NWORDS);
    check("full_res_count", res_count, 4);
    check("full_ready_low", acc_output_ready, 0);
    check("full_head", rd_data, res_pat(3, 0));
    rd_en = 1'b1;
    drive_cycles(1, 3, res_idx);
    rd_en = 1'b0;
    drive_cycles(5, 3, res_idx);
    check("full_one_more_push", res_idx, 5);
    check("full_res_count_after_pop", res_count, 5);
    check("full_ready_low_again", acc_output_ready, 0);
    check("full_head_after_pop", rd_data, res_pat(3, 1));

    // Reset mid-SEND at sent_count=500.
    do_reset();
    src_valid = 1'b1; acc_input_ready = 1'b1;
    start_job(11'd64);
    n = 0;
    while (sent_count != 11'd500 && n < 600) begin
      tick();
      n++;
    end
    check("midrst_reached_500", sent_count, 500);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sent_count", sent_count, 0);
    check("midrst_res_count", res_count, 0);
    check("midrst_rd_empty", rd_empty, 1);
    check("midrst_src_ready", src_ready, 0);
    check("midrst_acc_batch_size", acc_batch_size, 0);
    #10 reset_n = 1'b1;
    tick();
    check("midrst_idle_after_release", busy, 0);

    // Stalled input stream for longer than the watchdog window.
    do_reset();
    src_valid = 1'b1; acc_input_ready = 1'b0;
    start_job(11'd32);
    dn = 0;
    for (int i = 0; i < 4200; i++) begin
      tick();
      if (done) dn++;
    end
    check("stall_no_done", dn, 0);
    check("stall_sent_count", sent_count, 0);
`ifdef ACC_STREAM_TIMEOUT_EN
    check("stall_timeout", timeout, 1);
    check("stall_idle", busy, 0);
    start_job(11'd32);
    check("stall_timeout_cleared", timeout, 0);
    check("stall_restart_busy", busy, 1);
`else
    check("stall_timeout_tied", timeout, 0);
    check("stall_still_busy", busy, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
